// File: rtl/io_bank_pkg.sv
// Shared definitions for the I/O peripheral bank: register offsets, blank
// pattern for the seven-segment channels, register-select encoding and the
// byte-enable merge helper.
package io_bank_pkg;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BE_W        = DATA_W / 8;
  localparam int unsigned NUM_HEX_MAX = 8;

  localparam logic [ADDR_W-1:0] OFF_LEDR     = 8'h00;
  localparam logic [ADDR_W-1:0] OFF_LEDG     = 8'h04;
  localparam logic [ADDR_W-1:0] OFF_LCD      = 8'h08;
  localparam logic [ADDR_W-1:0] OFF_BLINK    = 8'h0C;
  localparam logic [ADDR_W-1:0] OFF_SW       = 8'h10;
  localparam logic [ADDR_W-1:0] OFF_HEX_BASE = 8'h20;

  // Segments are active-low: all bits high in [6:0] means every segment off.
  localparam logic [DATA_W-1:0] HEX_BLANK = 32'h0000_007F;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_LEDR,
    SEL_LEDG,
    SEL_LCD,
    SEL_BLINK,
    SEL_SW,
    SEL_HEX
  } reg_sel_e;

  // Replace each byte lane of old_val whose enable bit is set.
  function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old_val,
                                                 input logic [DATA_W-1:0] wdata,
                                                 input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] w_res;
    w_res = old_val;
    for (int k = 0; k < int'(BE_W); k++) begin
      if (be[k]) w_res[8*k +: 8] = wdata[8*k +: 8];
    end
    return w_res;
  endfunction

endpackage

// File: rtl/io_periph_bank_if.sv
// Request/response bus between the load/store unit (master) and the
// peripheral bank (slave).
//   req_valid_i/req_we_i/req_addr_i/req_wdata_i/req_be_i : request, one per cycle
//   rsp_valid_o/rsp_rdata_o/rsp_err_o                    : registered response
interface io_periph_bank_if;
  import io_bank_pkg::*;

  logic              req_valid_i;
  logic              req_we_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic [BE_W-1:0]   req_be_i;
  logic              rsp_valid_o;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

endinterface

// File: rtl/io_periph_bank_sw_debounce.sv
// Switch conditioning: two-flop synchroniser per bit followed by a per-bit
// saturating stability counter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   i_raw        : asynchronous switch inputs
//   o_stable     : debounced switch value
module sw_debounce #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_stable
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [CNT_W-1:0] r_cnt [WIDTH];

  // The flip happens on the edge that would bring the count to
  // DEBOUNCE_CYCLES, so the counter never holds that value and cannot wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      for (int i = 0; i < int'(WIDTH); i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/io_periph_bank.sv
// Memory-mapped peripheral bank: LED/LCD/hex registers, debounced switches,
// per-digit blink and a registered response with error flag.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   bus                 : request/response bus (slave side)
//   io_sw_i             : raw switch inputs
//   io_ledr_o/ledg/lcd  : register outputs
//   io_hex_o            : NUM_HEX packed 32-bit hex channels
module io_periph_bank
  import io_bank_pkg::*;
#(
  parameter int unsigned NUM_HEX         = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned BLINK_PERIOD    = 25_000_000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  io_periph_bank_if.slave        bus,
  input  logic [DATA_W-1:0]      io_sw_i,
  output logic [DATA_W-1:0]      io_ledr_o,
  output logic [DATA_W-1:0]      io_ledg_o,
  output logic [DATA_W-1:0]      io_lcd_o,
  output logic [NUM_HEX*32-1:0]  io_hex_o
);

  localparam int unsigned BCNT_W = $clog2(BLINK_PERIOD);

  logic [DATA_W-1:0]  r_ledr;
  logic [DATA_W-1:0]  r_ledg;
  logic [DATA_W-1:0]  r_lcd;
  logic [NUM_HEX-1:0] r_blink_en;
  logic [DATA_W-1:0]  r_hex [NUM_HEX];
  logic [BCNT_W-1:0]  r_bcnt;
  logic               r_blink_phase;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_rdata;
  logic               r_rsp_err;

  logic [DATA_W-1:0]  w_sw_stable;
  logic [ADDR_W-1:0]  w_addr;
  logic [2:0]         w_hex_idx;
  reg_sel_e           w_sel;
  logic [DATA_W-1:0]  w_rdata;
  logic [DATA_W-1:0]  w_wmerge;
  logic               w_wr;
  logic               w_rd;
  logic               w_err;

  sw_debounce #(
    .WIDTH           (DATA_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_raw    (io_sw_i),
    .o_stable (w_sw_stable)
  );

  // Address decode; the two low address bits are don't-care.
  always_comb begin
    w_addr    = bus.req_addr_i & 8'hFC;
    w_hex_idx = w_addr[4:2];
    w_sel     = SEL_NONE;
    case (w_addr)
      OFF_LEDR:  w_sel = SEL_LEDR;
      OFF_LEDG:  w_sel = SEL_LEDG;
      OFF_LCD:   w_sel = SEL_LCD;
      OFF_BLINK: w_sel = SEL_BLINK;
      OFF_SW:    w_sel = SEL_SW;
      default: begin
        if ((w_addr[7:5] == OFF_HEX_BASE[7:5]) && (32'(w_hex_idx) < NUM_HEX))
          w_sel = SEL_HEX;
      end
    endcase
  end

  // Current register value; also the base for byte-lane merging on writes.
  always_comb begin
    w_rdata = '0;
    case (w_sel)
      SEL_LEDR:  w_rdata = r_ledr;
      SEL_LEDG:  w_rdata = r_ledg;
      SEL_LCD:   w_rdata = r_lcd;
      SEL_BLINK: w_rdata = DATA_W'(r_blink_en);
      SEL_SW:    w_rdata = w_sw_stable;
      SEL_HEX: begin
        for (int i = 0; i < int'(NUM_HEX); i++) begin
          if (w_hex_idx == 3'(i)) w_rdata = r_hex[i];
        end
      end
      default:   w_rdata = '0;
    endcase
  end

  assign w_wmerge = be_merge(w_rdata, bus.req_wdata_i, bus.req_be_i);
  assign w_wr     = bus.req_valid_i & bus.req_we_i;
  assign w_rd     = bus.req_valid_i & ~bus.req_we_i;
  assign w_err    = bus.req_valid_i &
                    ((w_sel == SEL_NONE) | (bus.req_we_i & (w_sel == SEL_SW)));

  // Register file and response register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ledr      <= '0;
      r_ledg      <= '0;
      r_lcd       <= '0;
      r_blink_en  <= '0;
      for (int i = 0; i < int'(NUM_HEX); i++) r_hex[i] <= HEX_BLANK;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_rd;
      r_rsp_rdata <= w_rd ? w_rdata : '0;
      r_rsp_err   <= w_err;
      if (w_wr) begin
        case (w_sel)
          SEL_LEDR:  r_ledr     <= w_wmerge;
          SEL_LEDG:  r_ledg     <= w_wmerge;
          SEL_LCD:   r_lcd      <= w_wmerge;
          SEL_BLINK: r_blink_en <= w_wmerge[NUM_HEX-1:0];
          SEL_HEX: begin
            for (int i = 0; i < int'(NUM_HEX); i++) begin
              if (w_hex_idx == 3'(i)) r_hex[i] <= w_wmerge;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Free-running blink timebase, independent of bus traffic.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bcnt        <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_bcnt == BCNT_W'(BLINK_PERIOD - 1)) begin
      r_bcnt        <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_bcnt <= r_bcnt + BCNT_W'(1);
    end
  end

  assign io_ledr_o       = r_ledr;
  assign io_ledg_o       = r_ledg;
  assign io_lcd_o        = r_lcd;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rsp_rdata;
  assign bus.rsp_err_o   = r_rsp_err;

  for (genvar g = 0; g < int'(NUM_HEX); g++) begin : g_hex_out
    assign io_hex_o[32*g +: 32] = (r_blink_en[g] & r_blink_phase) ? HEX_BLANK : r_hex[g];
  end

endmodule

// File: tb/tb_io_periph_bank.sv
// Directed bench for io_periph_bank with small debounce/blink parameters.
module tb_io_periph_bank;

  localparam int unsigned NH = 8;
  localparam int unsigned DB = 4;
  localparam int unsigned BP = 4;

  logic           clk;
  logic           rst;
  logic [31:0]    sw;
  logic [31:0]    ledr;
  logic [31:0]    ledg;
  logic [31:0]    lcd;
  logic [NH*32-1:0] hex;

  int n_vec = 0;
  int n_err = 0;
  int m_cnt;
  logic m_phase;

  io_periph_bank_if bus ();

  io_periph_bank #(
    .NUM_HEX         (NH),
    .DEBOUNCE_CYCLES (DB),
    .BLINK_PERIOD    (BP)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .io_sw_i   (sw),
    .io_ledr_o (ledr),
    .io_ledg_o (ledg),
    .io_lcd_o  (lcd),
    .io_hex_o  (hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference blink timebase: wraps after BP cycles, phase starts at 0.
  always @(posedge clk) begin
    if (rst) begin
      m_cnt   <= 0;
      m_phase <= 1'b0;
    end else if (m_cnt == int'(BP) - 1) begin
      m_cnt   <= 0;
      m_phase <= ~m_phase;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  function automatic logic [31:0] hex_ch(input int c);
    return hex[32*c +: 32];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b1;
    bus.req_addr_i  = a;
    bus.req_wdata_i = d;
    bus.req_be_i    = be;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a);
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = a;
    bus.req_wdata_i = 32'h0;
    bus.req_be_i    = 4'h0;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
  endtask

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 8'h00;
    bus.req_wdata_i = 32'h0;
    bus.req_be_i    = 4'h0;
    sw  = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_ledr", ledr, 32'h0);
    chk("rst_ledg", ledg, 32'h0);
    chk("rst_lcd", lcd, 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
    for (int c = 0; c < int'(NH); c++) chk($sformatf("rst_hex%0d", c), hex_ch(c), 32'h7F);

    // Read SW after reset; response is a one-cycle pulse
    bus_rd(8'h10);
    chk("sw_rd_valid", 32'(bus.rsp_valid_o), 32'h1);
    chk("sw_rd_data", bus.rsp_rdata_o, 32'h0);
    chk("sw_rd_err", 32'(bus.rsp_err_o), 32'h0);
    @(posedge clk); #1;
    chk("sw_rd_pulse", 32'(bus.rsp_valid_o), 32'h0);

    // Byte-enable write, then back-to-back read
    bus_wr(8'h00, 32'hDEADBEEF, 4'b0101);
    chk("ledr_be", ledr, 32'h00AD00EF);
    chk("ledr_wr_err", 32'(bus.rsp_err_o), 32'h0);
    chk("ledr_wr_valid", 32'(bus.rsp_valid_o), 32'h0);
    bus_rd(8'h00);
    chk("ledr_rd_valid", 32'(bus.rsp_valid_o), 32'h1);
    chk("ledr_rd", bus.rsp_rdata_o, 32'h00AD00EF);

    bus_wr(8'h04, 32'h12345678, 4'hF);
    chk("ledg", ledg, 32'h12345678);
    bus_wr(8'h08, 32'hA5112233, 4'b1000);
    chk("lcd_be", lcd, 32'hA5000000);
    bus_rd(8'h0B);
    chk("lcd_rd_lowbits", bus.rsp_rdata_o, 32'hA5000000);

    // Upper BLINK_EN bits ignore writes
    bus_wr(8'h0C, 32'hFFFFFF00, 4'hF);
    bus_rd(8'h0C);
    chk("blink_upper", bus.rsp_rdata_o, 32'h0);

    // Read-only and unmapped accesses
    bus_wr(8'h10, 32'hFFFFFFFF, 4'hF);
    chk("sw_wr_err", 32'(bus.rsp_err_o), 32'h1);
    chk("sw_wr_valid", 32'(bus.rsp_valid_o), 32'h0);
    bus_rd(8'h44);
    chk("unmap_rd_err", 32'(bus.rsp_err_o), 32'h1);
    chk("unmap_rd_data", bus.rsp_rdata_o, 32'h0);
    bus_wr(8'h40, 32'h12345678, 4'hF);
    chk("unmap_wr_err", 32'(bus.rsp_err_o), 32'h1);
    chk("unmap_ledr", ledr, 32'h00AD00EF);
    bus_rd(8'h10);
    chk("sw_after_wr", bus.rsp_rdata_o, 32'h0);
    chk("sw_after_err", 32'(bus.rsp_err_o), 32'h0);
    bus_rd(8'h3C);
    chk("hex7_rd", bus.rsp_rdata_o, 32'h7F);
    chk("hex7_err", 32'(bus.rsp_err_o), 32'h0);

    // Glitch of DB-1 cycles must not reach SW
    @(negedge clk);
    sw = 32'h8;
    repeat (DB - 1) @(negedge clk);
    sw = 32'h0;
    repeat (DB + 4) @(negedge clk);
    bus_rd(8'h10);
    chk("sw_glitch", bus.rsp_rdata_o, 32'h0);

    // Held edge: SW updates 2+DB edges later; the read response lags one more
    @(negedge clk);
    sw = 32'h8;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 8'h10;
    for (int n = 1; n <= int'(DB) + 3; n++) begin
      @(posedge clk); #1;
      chk($sformatf("sw_edge_%0d", n), bus.rsp_rdata_o, (n >= int'(DB) + 3) ? 32'h8 : 32'h0);
    end
    bus.req_valid_i = 1'b0;

    // Blink on channel 2
    bus_wr(8'h28, 32'h40, 4'hF);
    chk("hex2_set", hex_ch(2), 32'h40);
    bus_wr(8'h0C, 32'h4, 4'h1);
    for (int n = 0; n < 12; n++) begin
      chk($sformatf("blink_ch2_%0d", n), hex_ch(2), m_phase ? 32'h7F : 32'h40);
      chk($sformatf("blink_ch0_%0d", n), hex_ch(0), 32'h7F);
      @(posedge clk); #1;
    end
    bus_rd(8'h28);
    chk("hex2_rd", bus.rsp_rdata_o, 32'h40);

    // Reset in the cycle after a read
    bus_wr(8'h00, 32'hFFFFFFFF, 4'hF);
    bus_rd(8'h00);
    chk("pre_rst_valid", 32'(bus.rsp_valid_o), 32'h1);
    chk("pre_rst_data", bus.rsp_rdata_o, 32'hFFFFFFFF);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(bus.rsp_valid_o), 32'h0);
    chk("mid_rst_ledr", ledr, 32'h0);
    chk("mid_rst_ledg", ledg, 32'h0);
    chk("mid_rst_hex2", hex_ch(2), 32'h7F);
    @(negedge clk);
    rst = 1'b0;

    // Reset together with a read request drops the response
    bus_wr(8'h04, 32'h0000FFFF, 4'hF);
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 8'h04;
    rst = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    chk("rst_drop_valid", 32'(bus.rsp_valid_o), 32'h0);
    chk("rst_drop_data", bus.rsp_rdata_o, 32'h0);
    chk("rst_drop_ledg", ledg, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus_rd(8'h0C);
    chk("post_rst_blink", bus.rsp_rdata_o, 32'h0);
    bus_rd(8'h28);
    chk("post_rst_hex2", bus.rsp_rdata_o, 32'h7F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_periph_bank.md
# io_periph_bank

Memory-mapped peripheral bank that sits between the pipelined CPU's load/store unit and the board I/O (switches, red/green LEDs, LCD, seven-segment displays). It generalises the fixed peripheral port set to a parametrised number of hex channels. It adds:
- a debounced and synchronised switch input
- per-digit hardware blink
- a registered request/response bus with byte enables and an error flag for unmapped accesses

## Interface
- NUM_HEX, 8: number of seven-segment channels, 1..8.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a switch bit updates; ≥1.
- BLINK_PERIOD, 25_000_000: cycles per blink half-period; ≥2.
- clk_i  in  1  single clock; all state is updated on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  1  bus request strobe; a request is accepted every cycle, with no stall.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  8  byte offset within the bank; bits [1:0] are ignored.
- req_wdata_i  in  32  write data.
- req_be_i  in  4  byte enables; applied on writes only.
- rsp_valid_o  out  1  read response valid.
- rsp_rdata_o  out  32  read data.
- rsp_err_o  out  1  unmapped access or write to a read-only register.
- io_sw_i  in  32  raw, asynchronous switch inputs.
- io_ledr_o, io_ledg_o, io_lcd_o  out  32 each  LED and LCD registers.
- io_hex_o  out  NUM_HEX×32  hex channels, packed; channel i occupies [32i+31:32i].

## Operation
- Register map (word offsets):
  - 0x00 LEDR
  - 0x04 LEDG
  - 0x08 LCD
  - 0x0C BLINK_EN, bits [NUM_HEX-1:0]; upper bits read 0 and ignore writes.
  - 0x10 SW, read-only debounced value.
  - 0x20+4i HEX i, for i < NUM_HEX.
  - Any other offset is unmapped.
- Write to a mapped read/write register: each byte lane with req_be_i[k]=1 is updated.
- Write to SW or to an unmapped offset: no state change; rsp_err_o=1 in the next cycle, rsp_valid_o=0.
- Read of a mapped register: register value returned. Read of an unmapped offset: rdata=0, err=1.
- Switch path:
  - 2-flop synchroniser per bit, then a per-bit counter.
  - The counter increments while the synchronised bit differs from the stable bit and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the stable bit flips and the counter clears.
- Blink:
  - A free-running counter 0..BLINK_PERIOD-1 toggles blink_phase when it wraps.
  - Driven value for hex channel i: HEX_BLANK (32'h0000_007F, segments active-low, all off) when BLINK_EN[i]=1 and blink_phase=1; otherwise the HEX i register.
- LEDR, LEDG and LCD drive their outputs directly from the registers.

## Timing
- Reset values:
  - LEDR, LEDG, LCD, BLINK_EN, SW stable value and debounce counters: 0.
  - HEX registers: HEX_BLANK.
  - Blink counter and blink_phase: 0.
  - rsp_valid_o, rsp_err_o, rsp_rdata_o: 0.
- Write latency: a write accepted in cycle N is visible on the io outputs in cycle N+1.
- Read latency: a read accepted in cycle N gives rsp_valid_o=1 with data in cycle N+1, for exactly one cycle.
- Back-to-back write then read of the same address: the read in N+1 returns the data written in N.
- Switch latency: a raw edge held stable reaches SW after 2 synchroniser cycles plus DEBOUNCE_CYCLES cycles. A glitch shorter than DEBOUNCE_CYCLES never reaches SW.
- BLINK_EN written in the same cycle as a phase toggle: the new enable applies from N+1. Blink phase itself is unaffected by bus traffic.
- Reset asserted mid-operation: any pending response is dropped, so rsp_valid_o=0 in the cycle after rst_i, and all state returns to its reset values.
- Counter wrap: the blink counter wraps exactly at BLINK_PERIOD-1. Debounce counters saturate; they never wrap.

## Structure
- io_bank_pkg holds:
  - register offset localparams (OFF_LEDR, OFF_LEDG, OFF_LCD, OFF_BLINK, OFF_SW, OFF_HEX_BASE)
  - HEX_BLANK
  - NUM_HEX_MAX=8
  - the byte-enable merge function
- Sub-module sw_debounce holds the synchroniser plus per-bit counters, parametrised on WIDTH and DEBOUNCE_CYCLES. The top level holds the register file, decode, blink logic and response register.

## Test plan
- Reset → all hex outputs 32'h7F, LEDR/LEDG/LCD 0, read of 0x10 returns 0 with rsp_valid_o one cycle after the request.
- Write 0xDEADBEEF to 0x00 with be=4'b0101 → io_ledr_o=0x00AD00EF next cycle; read of 0x00 returns the same value.
- Write to 0x10, then read of 0x44 with NUM_HEX=8 → rsp_err_o=1 on each, no state change, rdata=0 on the read.
- io_sw_i[3] pulsed high for DEBOUNCE_CYCLES-1 cycles → SW stays 0. Held high → SW=0x8 exactly 2+DEBOUNCE_CYCLES cycles after the edge.
- BLINK_PERIOD=4, HEX2=0x40, BLINK_EN=0x4 → io_hex channel 2 alternates between 0x40 and 0x7F every 4 cycles; other channels are steady.
- Assert rst_i in the cycle after a read request → no rsp_valid_o, LEDs cleared, hex channels blanked.
